regfile_wr_arbiter: RTL and testbench

REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

---
 rtl/regfile_wr_arbiter_if.sv | 39 +++
 rtl/regfile_wr_arbiter.sv | 102 ++++++++++
 tb/tb_regfile_wr_arbiter.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wr_arbiter_if.sv
// Register-file write arbiter bus: writeback, long-latency result, issue/scoreboard
// query and the registered register-file write port.
interface regfile_wr_arbiter_if #(
   parameter int unsigned DW = 64,
   parameter int unsigned CW = 2
);
   logic          i_wb_valid;
   logic [4:0]    i_wb_addr;
   logic [DW-1:0] i_wb_data;
   logic          i_ll_valid;
   logic [4:0]    i_ll_addr;
   logic [DW-1:0] i_ll_data;
   logic          o_ll_ready;
   logic          i_issue_valid;
   logic [4:0]    i_issue_rd;
   logic [4:0]    i_rs1;
   logic [4:0]    i_rs2;
   logic          o_rs1_busy;
   logic          o_rs2_busy;
   logic          o_issue_stall;
   logic          o_reg_write;
   logic [4:0]    o_wr_addr;
   logic [DW-1:0] o_wr_data;
   logic [CW-1:0] o_ll_count;

   modport master (
      output i_wb_valid, i_wb_addr, i_wb_data, i_ll_valid, i_ll_addr, i_ll_data,
      output i_issue_valid, i_issue_rd, i_rs1, i_rs2,
      input  o_ll_ready, o_rs1_busy, o_rs2_busy, o_issue_stall,
      input  o_reg_write, o_wr_addr, o_wr_data, o_ll_count
   );

   modport slave (
      input  i_wb_valid, i_wb_addr, i_wb_data, i_ll_valid, i_ll_addr, i_ll_data,
      input  i_issue_valid, i_issue_rd, i_rs1, i_rs2,
      output o_ll_ready, o_rs1_busy, o_rs2_busy, o_issue_stall,
      output o_reg_write, o_wr_addr, o_wr_data, o_ll_count
   );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Single write port arbiter: writeback first, then buffered long-latency results, then
// an LL bypass; also tracks which registers await a long-latency result.
module regfile_wr_arbiter #(
   parameter int unsigned XLEN     = 2,  // 2 selects 64-bit data
   parameter int unsigned LL_DEPTH = 2
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_clk_enable,
   regfile_wr_arbiter_if.slave bus
);
   localparam int unsigned DW = 1 << (XLEN + 4);
   localparam int unsigned PW = $clog2(LL_DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] DepthC = CW'(LL_DEPTH);

   logic [4:0]    buf_addr_q [LL_DEPTH];
   logic [DW-1:0] buf_data_q [LL_DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [31:0]   busy_q, busy_d;
   logic          reg_write_q, reg_write_d;
   logic [4:0]    wr_addr_q, wr_addr_d;
   logic [DW-1:0] wr_data_q, wr_data_d;

   logic ll_ready, ll_fire, ll_nz, wb_sel, buf_sel, byp_sel, push, pop;
   logic issue_stall, issue_set;

   always_comb begin
      ll_ready    = i_clk_enable & (count_q < DepthC);
      ll_fire     = bus.i_ll_valid & ll_ready;
      ll_nz       = (bus.i_ll_addr != 5'd0);
      wb_sel      = bus.i_wb_valid & (bus.i_wb_addr != 5'd0);
      buf_sel     = ~wb_sel & (count_q != '0);
      byp_sel     = ~wb_sel & (count_q == '0) & ll_fire & ll_nz;
      // x0 results complete the handshake but never occupy a buffer slot
      push        = ll_fire & ll_nz & ~byp_sel;
      pop         = buf_sel;
      issue_stall = bus.i_issue_valid & busy_q[bus.i_issue_rd];
      issue_set   = bus.i_issue_valid & (bus.i_issue_rd != 5'd0) & ~issue_stall;

      reg_write_d = wb_sel | buf_sel | byp_sel;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      busy_d      = busy_q;
      if (wb_sel) begin
         wr_addr_d = bus.i_wb_addr;
         wr_data_d = bus.i_wb_data;
      end else if (buf_sel) begin
         wr_addr_d = buf_addr_q[rd_ptr_q];
         wr_data_d = buf_data_q[rd_ptr_q];
         busy_d[buf_addr_q[rd_ptr_q]] = 1'b0;
      end else if (byp_sel) begin
         wr_addr_d = bus.i_ll_addr;
         wr_data_d = bus.i_ll_data;
         busy_d[bus.i_ll_addr] = 1'b0;
      end
      // Applied after the clear so a same-edge issue keeps the register busy
      if (issue_set) busy_d[bus.i_issue_rd] = 1'b1;
      busy_d[0] = 1'b0;

      count_d  = count_q + CW'(push) - CW'(pop);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      wr_ptr_d = wr_ptr_q + PW'(push);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         busy_q      <= '0;
         reg_write_q <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
      end else if (i_clk_enable) begin
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         busy_q      <= busy_d;
         reg_write_q <= reg_write_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_clk_enable && push) begin
         buf_addr_q[wr_ptr_q] <= bus.i_ll_addr;
         buf_data_q[wr_ptr_q] <= bus.i_ll_data;
      end
   end

   assign bus.o_ll_ready    = ll_ready;
   assign bus.o_issue_stall = issue_stall;
   assign bus.o_rs1_busy    = busy_q[bus.i_rs1];
   assign bus.o_rs2_busy    = busy_q[bus.i_rs2];
   assign bus.o_reg_write   = reg_write_q;
   assign bus.o_wr_addr     = wr_addr_q;
   assign bus.o_wr_data     = wr_data_q;
   assign bus.o_ll_count    = count_q;
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed scenarios plus randomized traffic against a
// queue-based reference model of the write-port rules.
module tb_regfile_wr_arbiter;
   localparam int unsigned LL_DEPTH = 2;
   localparam int unsigned DW = 64;
   localparam int unsigned CW = 2;

   logic i_clk = 1'b0;
   logic i_rst_n;
   logic i_clk_enable;
   regfile_wr_arbiter_if #(.DW(DW), .CW(CW)) bus ();

   regfile_wr_arbiter #(.XLEN(2), .LL_DEPTH(LL_DEPTH)) dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_clk_enable (i_clk_enable),
      .bus          (bus)
   );

   always #5 i_clk = ~i_clk;

   int checks = 0;
   int failures = 0;

   // Reference model state
   logic [4:0]    mq_addr [$];
   logic [DW-1:0] mq_data [$];
   bit   [31:0]   m_busy;
   bit            m_wr_v;
   logic [4:0]    m_wr_a;
   logic [DW-1:0] m_wr_d;

   task automatic model_reset();
      mq_addr.delete();
      mq_data.delete();
      m_busy = '0;
      m_wr_v = 1'b0;
      m_wr_a = '0;
      m_wr_d = '0;
   endtask

   task automatic idle();
      bus.i_wb_valid = 0; bus.i_wb_addr = 0; bus.i_wb_data = 0;
      bus.i_ll_valid = 0; bus.i_ll_addr = 0; bus.i_ll_data = 0;
      bus.i_issue_valid = 0; bus.i_issue_rd = 0; bus.i_rs1 = 0; bus.i_rs2 = 0;
   endtask

   // Predict the effect of the coming edge from the current inputs, then take the edge.
   task automatic model_clock();
      bit fire, stall, took_ll;
      if (i_clk_enable) begin
         fire    = bus.i_ll_valid && (mq_addr.size() < LL_DEPTH);
         stall   = bus.i_issue_valid && m_busy[bus.i_issue_rd];
         took_ll = 1'b0;
         if (bus.i_wb_valid && bus.i_wb_addr != 0) begin
            m_wr_v = 1; m_wr_a = bus.i_wb_addr; m_wr_d = bus.i_wb_data;
         end else if (mq_addr.size() != 0) begin
            m_wr_v = 1; m_wr_a = mq_addr.pop_front(); m_wr_d = mq_data.pop_front();
            m_busy[m_wr_a] = 1'b0;
         end else if (fire && bus.i_ll_addr != 0) begin
            m_wr_v = 1; m_wr_a = bus.i_ll_addr; m_wr_d = bus.i_ll_data;
            m_busy[m_wr_a] = 1'b0;
            took_ll = 1'b1;
         end else begin
            m_wr_v = 0;
         end
         if (fire && bus.i_ll_addr != 0 && !took_ll) begin
            mq_addr.push_back(bus.i_ll_addr);
            mq_data.push_back(bus.i_ll_data);
         end
         if (bus.i_issue_valid && bus.i_issue_rd != 0 && !stall) m_busy[bus.i_issue_rd] = 1'b1;
      end
      @(posedge i_clk);
      #1;
   endtask

   task automatic test_reset();
      i_clk_enable = 1; i_rst_n = 0; idle(); model_reset();
      #2;
      checks++; if (bus.o_ll_count !== 0) begin failures++;
         $display("FAIL reset_count got %0d want 0", bus.o_ll_count); end
      checks++; if (bus.o_reg_write !== 0) begin failures++;
         $display("FAIL reset_reg_write got %0b want 0", bus.o_reg_write); end
      checks++; if (bus.o_wr_addr !== 0 || bus.o_wr_data !== 0) begin failures++;
         $display("FAIL reset_wr got %0d/%0h want 0/0", bus.o_wr_addr, bus.o_wr_data); end
      checks++; if (bus.o_ll_ready !== 1) begin failures++;
         $display("FAIL reset_ready got %0b want 1", bus.o_ll_ready); end
      @(negedge i_clk); #1 i_rst_n = 1;
   endtask

   task automatic test_wb_only();
      idle(); bus.i_wb_valid = 1; bus.i_wb_addr = 5; bus.i_wb_data = 64'h1234;
      model_clock();
      checks++; if (bus.o_reg_write !== 1 || bus.o_wr_addr !== 5 || bus.o_wr_data !== 64'h1234)
      begin failures++; $display("FAIL wb_x5 got %0b/%0d/%0h want 1/5/1234",
         bus.o_reg_write, bus.o_wr_addr, bus.o_wr_data); end
      bus.i_wb_addr = 0; bus.i_wb_data = 64'h77;
      model_clock();
      checks++; if (bus.o_reg_write !== 0) begin failures++;
         $display("FAIL wb_x0 got %0b want 0", bus.o_reg_write); end
   endtask

   task automatic test_collision();
      idle(); bus.i_issue_valid = 1; bus.i_issue_rd = 7;
      model_clock();
      idle(); bus.i_wb_valid = 1; bus.i_wb_addr = 3; bus.i_wb_data = 64'hA;
      bus.i_ll_valid = 1; bus.i_ll_addr = 7; bus.i_ll_data = 64'hB; bus.i_rs1 = 7;
      model_clock();
      checks++; if (bus.o_reg_write !== 1 || bus.o_wr_addr !== 3 || bus.o_wr_data !== 64'hA)
      begin failures++; $display("FAIL coll_edge1 got %0b/%0d/%0h want 1/3/a",
         bus.o_reg_write, bus.o_wr_addr, bus.o_wr_data); end
      checks++; if (bus.o_ll_count !== 1 || bus.o_rs1_busy !== 1) begin failures++;
         $display("FAIL coll_count1 got %0d/%0b want 1/1", bus.o_ll_count, bus.o_rs1_busy); end
      idle(); bus.i_rs1 = 7;
      model_clock();
      checks++; if (bus.o_reg_write !== 1 || bus.o_wr_addr !== 7 || bus.o_wr_data !== 64'hB)
      begin failures++; $display("FAIL coll_edge2 got %0b/%0d/%0h want 1/7/b",
         bus.o_reg_write, bus.o_wr_addr, bus.o_wr_data); end
      checks++; if (bus.o_ll_count !== 0 || bus.o_rs1_busy !== 0) begin failures++;
         $display("FAIL coll_count0 got %0d/%0b want 0/0", bus.o_ll_count, bus.o_rs1_busy); end
   endtask

   task automatic test_backpressure();
      logic [4:0] a_exp [3];
      bit         r_exp [3];
      a_exp = '{5'd10, 5'd11, 5'd12};
      r_exp = '{1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 3; i++) begin
         idle(); bus.i_wb_valid = 1; bus.i_wb_addr = 5'(20 + i); bus.i_wb_data = 64'(i);
         bus.i_ll_valid = 1; bus.i_ll_addr = a_exp[i]; bus.i_ll_data = 64'(100 + i);
         #1;
         checks++; if (bus.o_ll_ready !== r_exp[i]) begin failures++;
            $display("FAIL bp_ready%0d got %0b want %0b", i, bus.o_ll_ready, r_exp[i]); end
         model_clock();
      end
      checks++; if (bus.o_ll_count !== 2) begin failures++;
         $display("FAIL bp_count got %0d want 2", bus.o_ll_count); end
      for (int i = 0; i < 2; i++) begin
         idle();
         model_clock();
         checks++; if (bus.o_reg_write !== 1 || bus.o_wr_addr !== a_exp[i] ||
                       bus.o_wr_data !== 64'(100 + i)) begin failures++;
            $display("FAIL bp_drain%0d got %0b/%0d/%0h want 1/%0d/%0h", i, bus.o_reg_write,
                     bus.o_wr_addr, bus.o_wr_data, a_exp[i], 100 + i); end
      end
   endtask

   task automatic test_scoreboard();
      idle(); bus.i_issue_valid = 1; bus.i_issue_rd = 9;
      model_clock();
      bus.i_rs1 = 9; bus.i_rs2 = 8; #1;
      checks++; if (bus.o_rs1_busy !== 1 || bus.o_rs2_busy !== 0) begin failures++;
         $display("FAIL sb_busy got %0b/%0b want 1/0", bus.o_rs1_busy, bus.o_rs2_busy); end
      checks++; if (bus.o_issue_stall !== 1) begin failures++;
         $display("FAIL sb_stall got %0b want 1", bus.o_issue_stall); end
      model_clock();
      idle(); bus.i_ll_valid = 1; bus.i_ll_addr = 9; bus.i_ll_data = 64'h99; bus.i_rs1 = 9;
      model_clock();
      checks++; if (bus.o_rs1_busy !== 0 || bus.o_wr_addr !== 9 || bus.o_reg_write !== 1)
      begin failures++; $display("FAIL sb_clear got %0b/%0d want 0/9",
         bus.o_rs1_busy, bus.o_wr_addr); end
      bus.i_issue_valid = 1; bus.i_issue_rd = 9; bus.i_ll_data = 64'h98;
      model_clock();
      checks++; if (bus.o_rs1_busy !== 1 || bus.o_wr_data !== 64'h98) begin failures++;
         $display("FAIL sb_setwins got %0b/%0h want 1/98", bus.o_rs1_busy, bus.o_wr_data); end
      idle(); bus.i_ll_valid = 1; bus.i_ll_addr = 9;
      model_clock();
   endtask

   task automatic test_x0_ll();
      idle(); bus.i_ll_valid = 1; bus.i_ll_addr = 0; bus.i_ll_data = 64'h5; #1;
      checks++; if (bus.o_ll_ready !== 1) begin failures++;
         $display("FAIL x0_ready got %0b want 1", bus.o_ll_ready); end
      model_clock();
      checks++; if (bus.o_reg_write !== 0 || bus.o_ll_count !== 0) begin failures++;
         $display("FAIL x0_drop got %0b/%0d want 0/0", bus.o_reg_write, bus.o_ll_count); end
   endtask

   task automatic test_enable();
      bit         prev_v;
      logic [4:0] prev_a;
      for (int i = 0; i < 2; i++) begin
         idle(); bus.i_wb_valid = 1; bus.i_wb_addr = 5'(1 + i); bus.i_wb_data = 64'(i);
         bus.i_ll_valid = 1; bus.i_ll_addr = 5'(14 + i); bus.i_ll_data = 64'(200 + i);
         model_clock();
      end
      prev_v = bus.o_reg_write; prev_a = bus.o_wr_addr;
      i_clk_enable = 0; bus.i_wb_addr = 6; bus.i_ll_valid = 1; #1;
      checks++; if (bus.o_ll_ready !== 0) begin failures++;
         $display("FAIL en_ready got %0b want 0", bus.o_ll_ready); end
      model_clock();
      model_clock();
      checks++; if (bus.o_ll_count !== 2 || bus.o_reg_write !== m_wr_v || bus.o_wr_addr !== m_wr_a)
      begin failures++; $display("FAIL en_hold got %0d/%0b/%0d want 2/%0b/%0d",
         bus.o_ll_count, bus.o_reg_write, bus.o_wr_addr, prev_v, prev_a); end
      i_clk_enable = 1; idle();
      model_clock();
      checks++; if (bus.o_wr_addr !== 14 || bus.o_wr_data !== 64'd200 || bus.o_ll_count !== 1)
      begin failures++; $display("FAIL en_resume got %0d/%0h/%0d want 14/c8/1",
         bus.o_wr_addr, bus.o_wr_data, bus.o_ll_count); end
      model_clock();
   endtask

   task automatic test_async_reset();
      idle(); bus.i_issue_valid = 1; bus.i_issue_rd = 4;
      bus.i_wb_valid = 1; bus.i_wb_addr = 1; bus.i_ll_valid = 1; bus.i_ll_addr = 10;
      model_clock();
      idle(); bus.i_wb_valid = 1; bus.i_wb_addr = 2; bus.i_ll_valid = 1; bus.i_ll_addr = 11;
      model_clock();
      idle(); bus.i_rs1 = 4; #1;
      checks++; if (bus.o_ll_count !== 2 || bus.o_rs1_busy !== 1) begin failures++;
         $display("FAIL ar_pre got %0d/%0b want 2/1", bus.o_ll_count, bus.o_rs1_busy); end
      i_rst_n = 0; model_reset(); #1;
      checks++; if (bus.o_ll_count !== 0 || bus.o_reg_write !== 0) begin failures++;
         $display("FAIL ar_now got %0d/%0b want 0/0", bus.o_ll_count, bus.o_reg_write); end
      for (int r = 0; r < 32; r++) begin
         bus.i_rs1 = 5'(r); #1;
         checks++; if (bus.o_rs1_busy !== 0) begin failures++;
            $display("FAIL ar_busy x%0d got %0b want 0", r, bus.o_rs1_busy); end
      end
      @(negedge i_clk); #1 i_rst_n = 1;
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         i_clk_enable      = ($urandom_range(0, 9) != 0);
         bus.i_wb_valid    = ($urandom_range(0, 9) < 4);
         bus.i_wb_addr     = 5'($urandom);
         bus.i_wb_data     = {$urandom, $urandom};
         bus.i_ll_valid    = ($urandom_range(0, 1) == 1);
         bus.i_ll_addr     = 5'($urandom);
         bus.i_ll_data     = {$urandom, $urandom};
         bus.i_issue_valid = ($urandom_range(0, 9) < 3);
         bus.i_issue_rd    = 5'($urandom);
         bus.i_rs1         = 5'($urandom);
         bus.i_rs2         = 5'($urandom);
         #1;
         checks++; if (bus.o_ll_ready !== (i_clk_enable && mq_addr.size() < LL_DEPTH)) begin
            failures++; $display("FAIL rnd_ready n=%0d got %0b", n, bus.o_ll_ready); end
         checks++; if (bus.o_ll_count !== CW'(mq_addr.size())) begin failures++;
            $display("FAIL rnd_count n=%0d got %0d want %0d", n, bus.o_ll_count,
                     mq_addr.size()); end
         checks++; if (bus.o_issue_stall !== (bus.i_issue_valid && m_busy[bus.i_issue_rd]))
         begin failures++; $display("FAIL rnd_stall n=%0d got %0b", n, bus.o_issue_stall); end
         checks++; if (bus.o_rs1_busy !== m_busy[bus.i_rs1] ||
                       bus.o_rs2_busy !== m_busy[bus.i_rs2]) begin failures++;
            $display("FAIL rnd_busy n=%0d got %0b/%0b want %0b/%0b", n, bus.o_rs1_busy,
                     bus.o_rs2_busy, m_busy[bus.i_rs1], m_busy[bus.i_rs2]); end
         model_clock();
         checks++; if (bus.o_reg_write !== m_wr_v) begin failures++;
            $display("FAIL rnd_wr_v n=%0d got %0b want %0b", n, bus.o_reg_write, m_wr_v); end
         if (m_wr_v) begin
            checks++; if (bus.o_wr_addr !== m_wr_a || bus.o_wr_data !== m_wr_d) begin
               failures++; $display("FAIL rnd_wr n=%0d got %0d/%0h want %0d/%0h", n,
                                    bus.o_wr_addr, bus.o_wr_data, m_wr_a, m_wr_d); end
         end
      end
      i_clk_enable = 1;
   endtask

   initial begin
      test_reset();
      test_wb_only();
      test_collision();
      test_backpressure();
      test_scoreboard();
      test_x0_ll();
      test_enable();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
